// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm bank setter and its digit stepper.
package alarm_pkg;

  localparam int BCD_W = 4;

  // Inclusive per-digit limits for an MM:SS alarm, 4 bits per digit.
  localparam logic [31:0] DIGIT_MAX_MMSS = 32'h0000_5959;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2,
    ABORT  = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement with an inclusive wrap limit.
// An out-of-range digit is pulled back to the limit by either step.
module bcd_digit_step
  import alarm_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic [BCD_W-1:0] max_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (up_i ^ down_i) begin
      if (digit_i > max_i) begin
        digit_o = max_i;
      end else if (up_i) begin
        digit_o = (digit_i == max_i) ? '0 : digit_i + 1'b1;
      end else begin
        digit_o = (digit_i == '0) ? max_i : digit_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_bank_setter.sv
// Multi-slot BCD alarm setter: cursor-based editing of a working copy,
// commit/abort into per-slot storage, and per-slot hit detection.
//
// state  | meaning
// IDLE   | waiting for edit_en rising edge; arm_toggle honoured
// EDIT   | working copy edited by push buttons
// COMMIT | one cycle: store working copy, arm slot, pulse done
// ABORT  | edit discarded; wait for edit_en low
module alarm_bank_setter
  import alarm_pkg::*;
#(
  parameter int                          N_DIGITS  = 4,
  parameter int                          N_ALARMS  = 4,
  parameter logic [BCD_W*N_DIGITS-1:0]   DIGIT_MAX = (BCD_W*N_DIGITS)'(DIGIT_MAX_MMSS),
  localparam int                         SW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  localparam int                         DW        = BCD_W * N_DIGITS
)(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   edit_en,
  input  logic [SW-1:0]          slot_sel,
  input  logic                   push_u,
  input  logic                   push_d,
  input  logic                   push_l,
  input  logic                   push_r,
  input  logic                   cancel,
  input  logic                   arm_toggle,
  input  logic [DW-1:0]          cur_time,
  output logic [N_DIGITS-1:0]    sel,
  output logic [DW-1:0]          edit_digits,
  output logic [N_ALARMS*DW-1:0] alarm_flat,
  output logic [N_ALARMS-1:0]    armed,
  output logic                   done,
  output logic [N_ALARMS-1:0]    hit
);

  localparam int                  IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] CUR_MSB = N_DIGITS'(1) << (N_DIGITS - 1);

  state_e                       state_q, state_d;
  logic                         edit_en_q;
  logic [SW-1:0]                cur_slot_q, cur_slot_d;
  logic [DW-1:0]                edit_q, edit_d;
  logic [N_DIGITS-1:0]          cur_q, cur_d;
  logic [N_ALARMS-1:0][DW-1:0]  slots_q, slots_d;
  logic [N_ALARMS-1:0]          armed_q, armed_d;
  logic [N_ALARMS-1:0]          hit_q, hit_d;
  logic [DW-1:0]                prev_time_q;
  logic [IW-1:0]                cur_idx;
  logic [BCD_W-1:0]             cur_digit, cur_max, step_digit;
  logic                         edit_rise;

  assign edit_rise = edit_en && !edit_en_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edit_rise) state_d = EDIT;
      EDIT: begin
        if (cancel)        state_d = ABORT;
        else if (!edit_en) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      ABORT:   if (!edit_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel  = (state_q == EDIT) ? cur_q : '1;
    done = (state_q == COMMIT);
  end

  always_comb begin
    cur_idx = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (cur_q[d]) cur_idx = IW'(d);
    end
  end

  assign cur_digit = edit_q[cur_idx*BCD_W +: BCD_W];
  assign cur_max   = DIGIT_MAX[cur_idx*BCD_W +: BCD_W];

  bcd_digit_step u_step (
    .digit_i (cur_digit),
    .max_i   (cur_max),
    .up_i    (push_u),
    .down_i  (push_d),
    .digit_o (step_digit)
  );

  // Digit step uses the cursor as it stood before this cycle's move.
  always_comb begin
    cur_slot_d = cur_slot_q;
    edit_d     = edit_q;
    cur_d      = cur_q;
    slots_d    = slots_q;
    armed_d    = armed_q;
    case (state_q)
      IDLE: begin
        if (edit_rise) begin
          cur_slot_d = slot_sel;
          edit_d     = slots_q[slot_sel];
          cur_d      = CUR_MSB;
        end
        if (arm_toggle) armed_d[slot_sel] = ~armed_q[slot_sel];
      end
      EDIT: begin
        if (!cancel && edit_en) begin
          edit_d[cur_idx*BCD_W +: BCD_W] = step_digit;
          if (push_l && !push_r) begin
            cur_d = (cur_q << 1) | (cur_q >> (N_DIGITS - 1));
          end else if (push_r && !push_l) begin
            cur_d = (cur_q >> 1) | (cur_q << (N_DIGITS - 1));
          end
        end
      end
      COMMIT: begin
        slots_d[cur_slot_q] = edit_q;
        armed_d[cur_slot_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // The slot being edited must not ring against its stale stored value.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      hit_d[i] = armed_q[i] && (cur_time != prev_time_q) && (cur_time == slots_q[i])
                 && !(((state_q == EDIT) || (state_q == COMMIT)) && (cur_slot_q == SW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      edit_en_q   <= 1'b0;
      cur_slot_q  <= '0;
      edit_q      <= '0;
      cur_q       <= '0;
      slots_q     <= '0;
      armed_q     <= '0;
      hit_q       <= '0;
      prev_time_q <= '0;
    end else begin
      edit_en_q   <= edit_en;
      cur_slot_q  <= cur_slot_d;
      edit_q      <= edit_d;
      cur_q       <= cur_d;
      slots_q     <= slots_d;
      armed_q     <= armed_d;
      hit_q       <= hit_d;
      prev_time_q <= cur_time;
    end
  end

  assign edit_digits = edit_q;
  assign alarm_flat  = slots_q;
  assign armed       = armed_q;
  assign hit         = hit_q;

endmodule

// File: doc/alarm_bank_setter.md
Name: alarm_bank_setter

Overview:
- Parametrised successor to the single-alarm setter. Holds N_ALARMS BCD alarm slots of N_DIGITS digits each, with a per-slot arm bit.
- Edits are made in a working copy using a one-hot digit cursor and per-digit wrap limits. The working copy is committed to the slot or discarded.
- Compares each armed slot against the running clock's BCD time and pulses a per-slot hit. Sits between the debounced push-button layer and the display/buzzer logic.

Parameters:
- N_DIGITS, 4: BCD digits per alarm; digit 0 is rightmost.
- N_ALARMS, 4: number of alarm slots.
- DIGIT_MAX, 32'h5959: packed 4 bits per digit, inclusive maximum of each digit (default = MM:SS, 0-5 / 0-9).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- edit_en  in  1  level from the mode switch; high = editing.
- slot_sel  in  SW = max(1, $clog2(N_ALARMS))  slot to edit/arm; sampled on edit entry or arm_toggle.
- push_u, push_d, push_l, push_r  in  1 each  single-cycle pulses from the debouncer.
- cancel  in  1  single-cycle pulse; abort current edit.
- arm_toggle  in  1  single-cycle pulse; flip armed[slot_sel]; honoured only in IDLE.
- cur_time  in  4*N_DIGITS  running time, BCD.
- sel  out  N_DIGITS  one-hot cursor while editing; all ones in IDLE.
- edit_digits  out  4*N_DIGITS  working copy, for display.
- alarm_flat  out  N_ALARMS*4*N_DIGITS  stored slots; slot i at [i*4N +: 4N].
- armed  out  N_ALARMS  per-slot enable.
- done  out  1  one-cycle pulse on commit.
- hit  out  N_ALARMS  one-cycle per-slot match pulse.

Behaviour:
- Reset (synchronous, resetn low at a clk edge):
  - Every output, register and slot clears to 0, except sel, which resets to all ones.
  - State returns to IDLE.
  - Reset mid-EDIT discards the working copy.
- State IDLE:
  - edit_en rising (registered previous value 0, current 1) -> EDIT.
  - On that edge: latch slot_sel into cur_slot, load edit_digits from that slot, set sel = MSB one-hot.
- State EDIT, one action per cycle, checked in this priority order:
  - cancel -> ABORT.
  - edit_en low -> COMMIT.
  - push_u and push_d both high -> no change.
  - push_u -> cursor digit +1; wraps to 0 after DIGIT_MAX[digit].
  - push_d -> cursor digit -1; 0 wraps to DIGIT_MAX[digit].
  - push_l and push_r both high -> no move.
  - push_l -> cursor one digit left; wraps from MSB to digit 0.
  - push_r -> cursor one digit right; wraps from digit 0 to MSB.
  - A digit update and a cursor move in the same cycle both apply; the digit update uses the pre-move cursor.
  - slot_sel changes during EDIT are ignored.
  - A loaded digit above its DIGIT_MAX is clamped to DIGIT_MAX on the first push_u or push_d.
- State COMMIT (1 cycle):
  - Write edit_digits into cur_slot and set armed[cur_slot] = 1.
  - done = 1 for this cycle only; sel = all ones; -> IDLE.
- State ABORT:
  - Stored slot untouched; sel = all ones; no done.
  - Wait until edit_en is low, then -> IDLE, so a still-high switch does not re-enter EDIT.
- arm_toggle:
  - In IDLE, flips armed[slot_sel] on the next edge.
  - Outside IDLE it is ignored and not queued.
- hit:
  - cur_time is registered every cycle as prev_time.
  - hit[i] = 1 for one cycle when armed[i], cur_time != prev_time, and cur_time == slot i.
  - A static match never re-fires.
  - hit for cur_slot is masked while state is EDIT or COMMIT.
  - Several slots may hit in the same cycle.
  - hit is a registered output, 1 cycle after the cur_time change.
- Latency: edit and cursor updates are visible on edit_digits / sel the cycle after the pulse. done is asserted the cycle after edit_en is sampled low.

Decomposition:
- Shared package (alarm_pkg):
  - State enum IDLE/EDIT/COMMIT/ABORT.
  - BCD digit width constant (4).
  - Default MM:SS DIGIT_MAX constant.
- Sub-module bcd_digit_step: combinational inc/dec of one digit with wrap limit and clamp; one instance for the cursor digit.

Test Plan:
- Reset: assert resetn=0 mid-EDIT, release -> alarm_flat=0, armed=0, sel=4'b1111, state IDLE, no done.
- Slot 2 edit to 10:59 (1059 BCD):
  - Sequence: edit_en=1, slot_sel=2, push_u on digit3; push_r; push_r, push_d on digit1 (0->5); push_r, push_d on digit0 (0->9); edit_en=0.
  - Required: slot2 = 16'h1059, armed[2]=1, done pulses exactly one cycle.
- Wrap limits:
  - Digit1 at 5, push_u -> 0; digit0 at 0, push_d -> 9.
  - Cursor on digit3, push_l -> sel 4'b0001; cursor on digit0, push_r -> sel 4'b1000.
  - push_u and push_d in the same cycle -> no change.
- Cancel: edit slot 1 from 0000 to 0300, cancel, keep edit_en high 5 cycles -> stays ABORT, slot1 still 0000, no done; edit_en low -> IDLE.
- Hit:
  - slot0=0005 armed, slot3=0005 armed; cur_time steps 0004 -> 0005 and holds 10 cycles -> hit=4'b1001 for exactly one cycle.
  - Disarm slot3 via arm_toggle, repeat -> hit=4'b0001.
- Edit masking: while editing slot0 (stored 0005), cur_time steps 0004 -> 0005 -> hit[0] stays 0.
